// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO: DEPTH x WIDTH register storage, strict in-order delivery.
// Latency: one cycle from write to dvld_o; no fall-through when empty.
// Backpressure: urdy_o = !full_o, never depends on drdy_i (no write-through when full).
module prim_fifo_sync #(
  parameter int WIDTH           = 32,
  parameter int DEPTH           = 4,
  parameter bit ZERO_ON_INVALID = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  output logic                     urdy_o,
  input  logic                     uvld_i,
  input  logic [WIDTH-1:0]         udat_i,
  input  logic                     drdy_i,
  output logic                     dvld_o,
  output logic [WIDTH-1:0]         ddat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("prim_fifo_sync: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  // Status flags come from the registered count only.
  assign full_o  = (count == FULL_CNT);
  assign empty_o = (count == '0);
  assign urdy_o  = ~full_o;
  assign dvld_o  = ~empty_o;
  assign count_o = count;

  // Transfer qualifiers; flush suppresses both so it wins over same-cycle traffic.
  assign do_wr = uvld_i & ~full_o & ~flush_i;
  assign do_rd = ~empty_o & drdy_i & ~flush_i;

  // Head entry, optionally masked to zero while nothing valid is stored.
  assign ddat_o = (ZERO_ON_INVALID && empty_o) ? '0 : mem[rptr];

  // Pointer and occupancy state; reset beats flush beats normal transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PTR_ONE;
      if (do_rd) rptr <= rptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; a write during reset is dropped since pointers restart anyway.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) begin
      mem[wptr] <= udat_i;
    end
  end

endmodule
